// File: rtl/cmd_interp_out_regbank.sv
// Output register bank for the calculator command interpreter: SLOTS indexed
// registers with valid flags, streamed out in ascending index order on request.
module cmd_interp_out_regbank #(
    parameter  int WIDTH = 8,
    parameter  int SLOTS = 4,
    localparam int SW    = $clog2(SLOTS),
    localparam int CW    = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [SW-1:0]    load_sel,
    input  logic             send,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic             err,
    output logic             state_dbg
);

    // Handshake: a value transfers on every rising edge where out_valid and
    // out_ready are both high; out/out_valid hold steady while out_ready is low.

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] slot [SLOTS];
    logic [SLOTS-1:0] vld;
    logic [SLOTS-1:0] vld_n;
    logic [SW-1:0]    idx;
    logic [SW-1:0]    nxt_idx;
    logic             nxt_found;
    logic             wr_bad;
    logic             wr_ok;
    logic             accept;
    logic [CW-1:0]    cnt_n;

    always_comb begin
        accept = (state == SEND) && out_ready;
        // The presented slot is locked so the value on out cannot change under the sink.
        wr_bad = (int'(load_sel) >= SLOTS) || ((state == SEND) && (load_sel == idx));
        wr_ok  = load && !wr_bad;

        vld_n = vld;
        if (accept) vld_n[idx] = 1'b0;
        if (wr_ok)  vld_n[load_sel] = 1'b1;

        // Lowest valid slot; while sending only slots above idx are eligible.
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (vld_n[i] && ((state == IDLE) || (i > int'(idx)))) begin
                nxt_found = 1'b1;
                nxt_idx   = SW'(i);
            end
        end

        cnt_n = '0;
        for (int i = 0; i < SLOTS; i++) begin
            cnt_n = cnt_n + CW'(vld_n[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            vld   <= '0;
            count <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (clear) begin
                state <= IDLE;
                idx   <= '0;
                vld   <= '0;
                count <= '0;
                for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
            end else begin
                err   <= load && wr_bad;
                if (wr_ok) slot[load_sel] <= in;
                vld   <= vld_n;
                count <= cnt_n;
                case (state)
                    IDLE: begin
                        if (send) begin
                            if (nxt_found) begin
                                state <= SEND;
                                idx   <= nxt_idx;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (accept) begin
                            if (nxt_found) begin
                                idx <= nxt_idx;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy      = (state == SEND);
    assign out_valid = (state == SEND);
    assign out       = (state == SEND) ? slot[idx] : '0;
    assign state_dbg = state;

endmodule

// File: doc/cmd_interp_out_regbank.md
# cmd_interp_out_regbank

Parametrised output register bank for the calculator command interpreter. Replaces the fixed two-register, two-load-strobe output stage with `SLOTS` indexed registers of `WIDTH` bits, each with a valid flag. On command, the bank streams the valid slots out in ascending index order over a valid/ready handshake. It sits between the command interpreter (writer) and the display/UART sender (reader).

## Interface
- `WIDTH`, 8, data width of each slot and of `in`/`out`.
- `SLOTS`, 4, number of slots, ≥2; `SW = $clog2(SLOTS)`, `CW = $clog2(SLOTS+1)`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserting low resets immediately; release is synchronous to `clk`.
- `in`  in  WIDTH  write data.
- `load`  in  1  write strobe; one write per cycle it is high.
- `load_sel`  in  SW  target slot of the write.
- `send`  in  1  start streaming pulse.
- `clear`  in  1  synchronous clear of all slots and flags; aborts streaming.
- `out`  out  WIDTH  current streamed value; 0 when `out_valid`=0.
- `out_valid`  out  1  `out` holds a slot awaiting acceptance.
- `out_ready`  in  1  sink accepts `out` when `out_valid`&`out_ready`.
- `busy`  out  1  high while in SEND.
- `done`  out  1  one-cycle pulse at end of a stream.
- `count`  out  CW  number of slots with valid flag set.
- `err`  out  1  one-cycle pulse on a rejected write.

## Operation
- Storage: `slot[0..SLOTS-1]` (WIDTH bits) and `vld[0..SLOTS-1]`.
- Write: `load`=1, `load_sel`<SLOTS → `slot[load_sel]`←`in`, `vld[load_sel]`←1 at the edge. Rewriting an already-valid slot overwrites it; `count` is unchanged.
- Rejected writes: `load_sel`≥SLOTS, or a write to the slot currently presented on `out` during SEND. The write is dropped and `err` pulses the next cycle.
- FSM states IDLE and SEND:
  - IDLE + `send` + any `vld` → SEND, with `idx` = lowest valid index.
  - IDLE + `send` + no `vld` → stay IDLE; `done` pulses.
  - SEND: `out`=`slot[idx]`, `out_valid`=1. On accept, `vld[idx]`←0 and `idx`←next valid index > `idx`. If none remains, go to IDLE and pulse `done`.
  - `send` while in SEND is ignored.
- Write during SEND:
  - To a slot > `idx`: stored, and included in the current stream.
  - To a slot < `idx`: stored and flagged, but not sent in this stream.
- `clear` (priority over `load` and `send`): all `slot`←0, all `vld`←0, state→IDLE, `out_valid`←0. No `done` pulse. A `load` in the same cycle is discarded without `err`.
- `count` is registered and equals the popcount of `vld` after each edge. A simultaneous accept and write to another slot nets correctly, e.g. 3→3.

## Timing
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `done`=0, `count`=0, `err`=0, all slots and flags 0, state IDLE.
- Write → `count`/`vld` visible 1 cycle later.
- `send` in IDLE at edge N → `out_valid`=1 and `busy`=1 from cycle N+1.
- Back-to-back accepts give 1 value per cycle. `out_valid` stays high between consecutive slots, and `out` changes on the accept edge.
- `out` and `out_valid` are held stable while `out_ready`=0.
- Last accept at edge M → cycle M+1: `out_valid`=0, `busy`=0, `done`=1 for exactly one cycle.
- `rst` asserted mid-stream → outputs drop to their reset values immediately. No `done`; stored data is lost.

## Test plan
- Reset, then `load` 0x11→slot 1 and 0x33→slot 3 → `count`=2. `send` with `out_ready`=1 → `out` 0x11, then 0x33 on consecutive cycles; `done` one cycle after; `count`=0.
- Stream slots 0,1,2 = 0xA0,0xA1,0xA2 with `out_ready` low for 3 cycles on the first value → `out` holds 0xA0 stable, with no skipped or duplicated values.
- During SEND at `idx`=1: write 0x55→slot 3 (sent in this stream), 0x66→slot 0 (not sent; `count`=1 after `done`), 0x77→slot 1 (`err` pulse, `out` stays at the old slot 1 value).
- `load_sel`=SLOTS with `SLOTS`=5 → `err` pulse, `count` unchanged. `send` with no valid slots → `done` next cycle and `busy` stays 0.
- `clear` asserted mid-stream together with `load` → next cycle `out_valid`=0, `busy`=0, `count`=0, no `done`, no `err`.
- `rst` driven low asynchronously between edges mid-stream → `out_valid`, `busy` and `count` go to 0 before the next edge. After release, `send` → immediate `done`.
